// File: rtl/j2_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : j2_stack_pkg
// Brief    : Shared defaults and stack-delta encoding for the j2 stacks.
// Revision : 1.0
// ============================================================================
package j2_stack_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  // Two's complement pointer move so decode and stack agree on meaning
  typedef enum logic [1:0] {
    SD_NONE = 2'b00,
    SD_PUSH = 2'b01,
    SD_POP2 = 2'b10,
    SD_POP  = 2'b11
  } sd_e;

endpackage
`default_nettype wire

// File: rtl/j2_stack_if.sv
`default_nettype none
// ============================================================================
// Module   : j2_stack_if
// Brief    : Control/data bundle between a stack user and a j2_stack.
// Revision : 1.0
// ============================================================================
interface j2_stack_if #(
  parameter int WIDTH = j2_stack_pkg::DEF_WIDTH,
  parameter int DEPTH = j2_stack_pkg::DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             clear;
  logic [1:0]       delta;
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] second;
  logic [AW-1:0]    sp;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, delta, we, wdata,
    input  top, second, sp, count, empty, full, overflow, underflow
  );

  modport slave (
    input  clear, delta, we, wdata,
    output top, second, sp, count, empty, full, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/j2_stack.sv
`default_nettype none
// ============================================================================
// Module   : j2_stack
// Brief    : Register-file stack with occupancy, sticky flags, wrap/guard mode.
// Revision : 1.0
// ============================================================================
module j2_stack
  import j2_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter bit WRAP  = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   resetq,
  j2_stack_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_sp;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [AW:0]      w_dext;
  logic [AW-1:0]    w_sp_n;
  logic             w_ovf;
  logic             w_unf;
  logic             w_exec;
  logic [AW:0]      w_count_n;

  assign w_dext = {{(AW-1){bus.delta[1]}}, bus.delta};
  assign w_sp_n = r_sp + w_dext[AW-1:0];

  assign w_ovf = (bus.delta == SD_PUSH) && (r_count == C_FULL);
  assign w_unf = ((bus.delta == SD_POP)  && (r_count == '0)) ||
                 ((bus.delta == SD_POP2) && (r_count < (AW+1)'(2)));

  // Guard mode drops an illegal op entirely; wrap mode lets it run
  assign w_exec = !(w_ovf || w_unf) || WRAP;

  assign w_count_n = w_ovf ? C_FULL :
                     w_unf ? '0     : r_count + w_dext;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.clear) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_ovf) r_ovf <= 1'b1;
      if (w_unf) r_unf <= 1'b1;
      if (w_exec) begin
        r_sp    <= w_sp_n;
        r_count <= w_count_n;
        if (bus.we) r_mem[w_sp_n] <= bus.wdata;
      end
    end
  end

  assign bus.top       = r_mem[r_sp];
  assign bus.second    = r_mem[r_sp - AW'(1)];
  assign bus.sp        = r_sp;
  assign bus.count     = r_count;
  assign bus.empty     = (r_count == '0);
  assign bus.full      = (r_count == C_FULL);
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_j2_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_j2_stack
// Brief    : Directed + random bench for three j2_stack configurations.
// Revision : 1.0
// ============================================================================
module tb_j2_stack;
  import j2_stack_pkg::*;

  logic        clk    = 1'b0;
  logic        resetq = 1'b0;
  logic        clear  = 1'b0;
  logic [1:0]  delta  = 2'b00;
  logic        we     = 1'b0;
  logic [15:0] wdata  = 16'h0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instance 0: 16 deep wrap, 1: 4 deep wrap, 2: 4 deep guard
  j2_stack_if #(.WIDTH(16), .DEPTH(16)) b0 ();
  j2_stack_if #(.WIDTH(16), .DEPTH(4))  b1 ();
  j2_stack_if #(.WIDTH(16), .DEPTH(4))  b2 ();

  assign b0.clear = clear; assign b0.delta = delta; assign b0.we = we; assign b0.wdata = wdata;
  assign b1.clear = clear; assign b1.delta = delta; assign b1.we = we; assign b1.wdata = wdata;
  assign b2.clear = clear; assign b2.delta = delta; assign b2.we = we; assign b2.wdata = wdata;

  j2_stack #(.WIDTH(16), .DEPTH(16), .WRAP(1'b1)) u0 (.clk(clk), .resetq(resetq), .bus(b0));
  j2_stack #(.WIDTH(16), .DEPTH(4),  .WRAP(1'b1)) u1 (.clk(clk), .resetq(resetq), .bus(b1));
  j2_stack #(.WIDTH(16), .DEPTH(4),  .WRAP(1'b0)) u2 (.clk(clk), .resetq(resetq), .bus(b2));

  logic [15:0] o_top [3];
  logic [15:0] o_sec [3];
  logic [3:0]  o_sp  [3];
  logic [4:0]  o_cnt [3];
  logic        o_emp [3];
  logic        o_ful [3];
  logic        o_ovf [3];
  logic        o_unf [3];

  assign o_top[0] = b0.top;    assign o_top[1] = b1.top;    assign o_top[2] = b2.top;
  assign o_sec[0] = b0.second; assign o_sec[1] = b1.second; assign o_sec[2] = b2.second;
  assign o_sp[0]  = b0.sp;     assign o_sp[1]  = 4'(b1.sp); assign o_sp[2]  = 4'(b2.sp);
  assign o_cnt[0] = b0.count;  assign o_cnt[1] = 5'(b1.count); assign o_cnt[2] = 5'(b2.count);
  assign o_emp[0] = b0.empty;  assign o_emp[1] = b1.empty;  assign o_emp[2] = b2.empty;
  assign o_ful[0] = b0.full;   assign o_ful[1] = b1.full;   assign o_ful[2] = b2.full;
  assign o_ovf[0] = b0.overflow;  assign o_ovf[1] = b1.overflow;  assign o_ovf[2] = b2.overflow;
  assign o_unf[0] = b0.underflow; assign o_unf[1] = b1.underflow; assign o_unf[2] = b2.underflow;

  // Reference model: plain integer stack bookkeeping per instance
  int dep [3] = '{16, 4, 4};
  bit wrp [3] = '{1'b1, 1'b1, 1'b0};
  int m_mem [3][16];
  int m_sp  [3];
  int m_cnt [3];
  bit m_ov  [3];
  bit m_un  [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sp[i] = 0; m_cnt[i] = 0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
      for (int k = 0; k < 16; k++) m_mem[i][k] = 0;
    end
  endtask

  task automatic model_step();
    int d;
    bit ov, un;
    case (delta)
      2'b01:   d = 1;
      2'b11:   d = -1;
      2'b10:   d = -2;
      default: d = 0;
    endcase
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        m_sp[i] = 0; m_cnt[i] = 0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
      end else begin
        ov = (d == 1) && (m_cnt[i] == dep[i]);
        un = (d < 0) && (m_cnt[i] < -d);
        if (ov) m_ov[i] = 1'b1;
        if (un) m_un[i] = 1'b1;
        if (!(ov || un) || wrp[i]) begin
          m_sp[i] = (m_sp[i] + d + dep[i]) % dep[i];
          if (we) m_mem[i][m_sp[i]] = int'(wdata);
          if (ov)      m_cnt[i] = dep[i];
          else if (un) m_cnt[i] = 0;
          else         m_cnt[i] = m_cnt[i] + d;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.top", i),    32'(o_top[i]), 32'(m_mem[i][m_sp[i]]));
      chk($sformatf("u%0d.second", i), 32'(o_sec[i]), 32'(m_mem[i][(m_sp[i] + dep[i] - 1) % dep[i]]));
      chk($sformatf("u%0d.sp", i),     32'(o_sp[i]),  32'(m_sp[i]));
      chk($sformatf("u%0d.count", i),  32'(o_cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("u%0d.empty", i),  32'(o_emp[i]), 32'(m_cnt[i] == 0));
      chk($sformatf("u%0d.full", i),   32'(o_ful[i]), 32'(m_cnt[i] == dep[i]));
      chk($sformatf("u%0d.ovf", i),    32'(o_ovf[i]), 32'(m_ov[i]));
      chk($sformatf("u%0d.unf", i),    32'(o_unf[i]), 32'(m_un[i]));
    end
  endtask

  task automatic cycle(input logic c, input logic [1:0] d, input logic w, input logic [15:0] x);
    clear = c; delta = d; we = w; wdata = x;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int r;
    model_reset();
    #2;
    check_all();
    chk("reset.empty", 32'(o_emp[0]), 32'd1);
    #10 resetq = 1'b1;

    // Four pushes on the 16-deep stack
    for (int k = 1; k <= 4; k++) cycle(1'b0, 2'b01, 1'b1, 16'(k));
    chk("plan.sp4",  32'(o_sp[0]),  32'd4);
    chk("plan.cnt4", 32'(o_cnt[0]), 32'd4);
    chk("plan.top4", 32'(o_top[0]), 32'd4);
    chk("plan.sec3", 32'(o_sec[0]), 32'd3);
    cycle(1'b0, 2'b10, 1'b1, 16'd7);
    chk("pop2.sp",  32'(o_sp[0]),  32'd2);
    chk("pop2.top", 32'(o_top[0]), 32'd7);
    chk("pop2.sec", 32'(o_sec[0]), 32'd1);
    chk("pop2.cnt", 32'(o_cnt[0]), 32'd2);
    cycle(1'b0, 2'b00, 1'b1, 16'd9);
    chk("repl.top", 32'(o_top[0]), 32'd9);
    chk("repl.sp",  32'(o_sp[0]),  32'd2);

    // Overflow on the 4-deep instances
    cycle(1'b1, 2'b00, 1'b0, 16'd0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 2'b01, 1'b1, 16'(16'hA + k));
    chk("wrap.sp",  32'(o_sp[1]),  32'd1);
    chk("wrap.top", 32'(o_top[1]), 32'hE);
    chk("wrap.sec", 32'(o_sec[1]), 32'hD);
    chk("wrap.ovf", 32'(o_ovf[1]), 32'd1);
    chk("grd.sp",   32'(o_sp[2]),  32'd0);
    chk("grd.top",  32'(o_top[2]), 32'hD);
    chk("grd.cnt",  32'(o_cnt[2]), 32'd4);
    chk("grd.ovf",  32'(o_ovf[2]), 32'd1);

    // Underflow drop in guard mode
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'b11, 1'b0, 16'd0);
    cycle(1'b0, 2'b10, 1'b0, 16'd0);
    chk("grd.unf",    32'(o_unf[2]), 32'd1);
    chk("grd.unf.sp", 32'(o_sp[2]),  32'd1);

    // Clear beats a simultaneous push; memory retained
    cycle(1'b1, 2'b01, 1'b1, 16'h55);
    chk("clr.sp", 32'(o_sp[2]), 32'd0);
    cycle(1'b0, 2'b01, 1'b0, 16'd0);
    chk("clr.mem1", 32'(o_top[2]), 32'hA);

    // Asynchronous reset between edges
    cycle(1'b0, 2'b01, 1'b1, 16'h11);
    #2 resetq = 1'b0;
    model_reset();
    #1 check_all();
    #1 resetq = 1'b1;
    cycle(1'b0, 2'b01, 1'b1, 16'h22);
    chk("rst.sp1", 32'(o_sp[0]), 32'd1);

    // Randomised traffic, biased so occupancy wanders in both directions
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      cycle(($urandom_range(0, 31) == 0),
            (r < 5) ? 2'b01 : (r < 7) ? 2'b00 : (r < 9) ? 2'b11 : 2'b10,
            1'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
